gf_mul_32_arbiter: RTL and testbench

//  Shares one gf_mul_32 instance between N_REQ requesters in GF32_MUL_SHARED builds.

---
 rtl/gf_mul_32_arbiter_pkg.sv | 12 +
 rtl/gf_mul_32_arbiter_rr_priority_sel.sv | 34 +++
 rtl/gf_mul_32_arbiter.sv | 148 ++++++++++++++
 tb/tb_gf_mul_32_arbiter.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/gf_mul_32_arbiter_pkg.sv
// Shared types and constants for the gf_mul_32 round-robin arbiter.
package gf_mul_32_arbiter_pkg;

  localparam int unsigned GF_WIDTH = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/gf_mul_32_arbiter_rr_priority_sel.sv
// Round-robin priority selector: first pending index after ptr_i (wrapping) wins.
module rr_priority_sel #(
  parameter int N_REQ = 4,
  parameter int PW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending_i,
  input  logic [PW-1:0]    ptr_i,
  output logic [PW-1:0]    grant_o,
  output logic             valid_o
);

  logic [PW-1:0] idx_s;

  // Walk N_REQ positions starting just after the pointer; lock onto the first pending one.
  always_comb begin
    grant_o = '0;
    valid_o = 1'b0;
    idx_s   = ptr_i;
    for (int i = 0; i < N_REQ; i++) begin
      if (idx_s == PW'(N_REQ - 1)) begin
        idx_s = '0;
      end else begin
        idx_s = idx_s + PW'(1);
      end
      if (!valid_o && pending_i[idx_s]) begin
        valid_o = 1'b1;
        grant_o = idx_s;
      end else begin
        valid_o = valid_o;
      end
    end
  end

endmodule

// File: rtl/gf_mul_32_arbiter.sv
// Shares a single gf_mul_32 between N_REQ requesters with round-robin grants,
// queuing one operand pair per requester and returning the product with a done pulse.
module gf_mul_32_arbiter
  import gf_mul_32_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int WIDTH = GF_WIDTH
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_start_req,
  input  logic [N_REQ*WIDTH-1:0] i_x_req,
  input  logic [N_REQ*WIDTH-1:0] i_y_req,
  output logic [N_REQ-1:0]       o_done_req,
  output logic [WIDTH-1:0]       o_o_req,
  output logic [N_REQ-1:0]       o_busy_req,
  output logic                   o_start_mul,
  output logic [WIDTH-1:0]       o_x_mul,
  output logic [WIDTH-1:0]       o_y_mul,
  input  logic [WIDTH-1:0]       i_o_mul,
  input  logic                   i_done_mul
);

  localparam int PW = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [N_REQ-1:0] pend_q, pend_d;
  logic [WIDTH-1:0] x_slot_q [N_REQ];
  logic [WIDTH-1:0] x_slot_d [N_REQ];
  logic [WIDTH-1:0] y_slot_q [N_REQ];
  logic [WIDTH-1:0] y_slot_d [N_REQ];
  logic [PW-1:0]    grant_q, grant_d;
  logic [PW-1:0]    ptr_q, ptr_d;
  logic             start_q, start_d;
  logic [WIDTH-1:0] x_mul_q, x_mul_d;
  logic [WIDTH-1:0] y_mul_q, y_mul_d;
  logic [WIDTH-1:0] prod_q, prod_d;
  logic [N_REQ-1:0] done_q, done_d;

  logic [PW-1:0]    sel_grant_s;
  logic             sel_valid_s;

  rr_priority_sel #(
    .N_REQ (N_REQ),
    .PW    (PW)
  ) u_sel (
    .pending_i (pend_q),
    .ptr_i     (ptr_q),
    .grant_o   (sel_grant_s),
    .valid_o   (sel_valid_s)
  );

  // Next-state: request capture, arbitration FSM and completion hand-back.
  always_comb begin
    state_d  = state_q;
    pend_d   = pend_q;
    x_slot_d = x_slot_q;
    y_slot_d = y_slot_q;
    grant_d  = grant_q;
    ptr_d    = ptr_q;
    start_d  = 1'b0;
    x_mul_d  = x_mul_q;
    y_mul_d  = y_mul_q;
    prod_d   = prod_q;
    done_d   = '0;

    // A start from a busy requester is dropped; its slot must not be disturbed.
    for (int k = 0; k < N_REQ; k++) begin
      if (i_start_req[k] && !pend_q[k]) begin
        pend_d[k]   = 1'b1;
        x_slot_d[k] = i_x_req[k*WIDTH +: WIDTH];
        y_slot_d[k] = i_y_req[k*WIDTH +: WIDTH];
      end else begin
        pend_d[k] = pend_d[k];
      end
    end

    case (state_q)
      ST_IDLE: begin
        if (sel_valid_s) begin
          grant_d = sel_grant_s;
          ptr_d   = sel_grant_s;
          x_mul_d = x_slot_q[sel_grant_s];
          y_mul_d = y_slot_q[sel_grant_s];
          start_d = 1'b1;
          state_d = ST_ISSUE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (i_done_mul) begin
          prod_d          = i_o_mul;
          done_d[grant_q] = 1'b1;
          pend_d[grant_q] = 1'b0;
          state_d         = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and output registers; the pointer resets to the last index so requester 0 goes first.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      pend_q  <= '0;
      for (int k = 0; k < N_REQ; k++) begin
        x_slot_q[k] <= '0;
        y_slot_q[k] <= '0;
      end
      grant_q <= '0;
      ptr_q   <= PW'(N_REQ - 1);
      start_q <= 1'b0;
      x_mul_q <= '0;
      y_mul_q <= '0;
      prod_q  <= '0;
      done_q  <= '0;
    end else begin
      state_q  <= state_d;
      pend_q   <= pend_d;
      x_slot_q <= x_slot_d;
      y_slot_q <= y_slot_d;
      grant_q  <= grant_d;
      ptr_q    <= ptr_d;
      start_q  <= start_d;
      x_mul_q  <= x_mul_d;
      y_mul_q  <= y_mul_d;
      prod_q   <= prod_d;
      done_q   <= done_d;
    end
  end

  assign o_done_req  = done_q;
  assign o_o_req     = prod_q;
  assign o_busy_req  = pend_q;
  assign o_start_mul = start_q;
  assign o_x_mul     = x_mul_q;
  assign o_y_mul     = y_mul_q;

endmodule

// File: tb/tb_gf_mul_32_arbiter.sv
// Scoreboard bench for gf_mul_32_arbiter with a fixed-latency GF(2^32) multiplier model.
module tb_gf_mul_32_arbiter;

  localparam int N = 4;
  localparam int W = 32;
  localparam int L = 3;

  typedef struct {
    logic [N-1:0] who;
    logic [W-1:0] prod;
  } exp_t;

  logic           i_clk = 1'b0;
  logic           i_rst;
  logic [N-1:0]   i_start_req;
  logic [N*W-1:0] i_x_req;
  logic [N*W-1:0] i_y_req;
  logic [N-1:0]   o_done_req;
  logic [W-1:0]   o_o_req;
  logic [N-1:0]   o_busy_req;
  logic           o_start_mul;
  logic [W-1:0]   o_x_mul;
  logic [W-1:0]   o_y_mul;
  logic [W-1:0]   i_o_mul;
  logic           i_done_mul;

  logic           m_busy = 1'b0;
  logic           m_done = 1'b0;
  int             m_cnt = 0;
  logic [W-1:0]   m_x = '0;
  logic [W-1:0]   m_y = '0;
  logic [W-1:0]   m_o = '0;
  logic           stray_done = 1'b0;
  logic [W-1:0]   stray_o = '0;

  exp_t           sb[$];
  int             n_tests = 0;
  int             n_fail = 0;
  int             n_starts = 0;
  logic           inflight = 1'b0;
  logic [W-1:0]   hold_x, hold_y;

  gf_mul_32_arbiter #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_start_req (i_start_req),
    .i_x_req     (i_x_req),
    .i_y_req     (i_y_req),
    .o_done_req  (o_done_req),
    .o_o_req     (o_o_req),
    .o_busy_req  (o_busy_req),
    .o_start_mul (o_start_mul),
    .o_x_mul     (o_x_mul),
    .o_y_mul     (o_y_mul),
    .i_o_mul     (i_o_mul),
    .i_done_mul  (i_done_mul)
  );

  always #5 i_clk = ~i_clk;

  function automatic logic [W-1:0] gf_mul(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] p, aa;
    logic         c;
    p  = '0;
    aa = a;
    for (int i = 0; i < W; i++) begin
      if (b[i]) p = p ^ aa;
      c  = aa[W-1];
      aa = aa << 1;
      if (c) aa = aa ^ 32'h0000008D;
    end
    return p;
  endfunction

  // Multiplier stand-in: L cycles from the start edge to the done pulse; ignores arbiter reset.
  always @(posedge i_clk) begin
    m_done <= 1'b0;
    if (m_busy) begin
      if (m_cnt == 1) begin
        m_done <= 1'b1;
        m_o    <= gf_mul(m_x, m_y);
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
    if (o_start_mul) begin
      m_busy <= 1'b1;
      m_cnt  <= L;
      m_x    <= o_x_mul;
      m_y    <= o_y_mul;
    end
  end

  assign i_done_mul = m_done | stray_done;
  assign i_o_mul    = stray_done ? stray_o : m_o;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic push(input int k, input logic [W-1:0] p);
    exp_t e;
    e.who  = N'(1) << k;
    e.prod = p;
    sb.push_back(e);
  endtask

  task automatic set_req(input int k, input logic [W-1:0] x, input logic [W-1:0] y);
    i_x_req[k*W +: W] = x;
    i_y_req[k*W +: W] = y;
  endtask

  task automatic fire(input logic [N-1:0] m);
    i_start_req = m;
    @(negedge i_clk);
    i_start_req = '0;
  endtask

  task automatic wait_done();
    logic seen;
    seen = 1'b0;
    for (int c = 0; c < 60 && !seen; c++) begin
      @(negedge i_clk);
      if (o_done_req != '0) seen = 1'b1;
    end
    n_tests++;
    if (!seen) begin
      n_fail++;
      $display("FAIL done_timeout: got no o_done_req expected one within 60 cycles");
    end
  endtask

  // Monitor: scoreboard pops on every done, operand hold check while a multiply is in flight.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (i_rst) begin
        inflight = 1'b0;
      end else begin
        if (o_start_mul) begin
          n_starts++;
          hold_x   = o_x_mul;
          hold_y   = o_y_mul;
          inflight = 1'b1;
        end else if (inflight) begin
          chk("x_mul_hold", o_x_mul, hold_x);
          chk("y_mul_hold", o_y_mul, hold_y);
          if (i_done_mul) inflight = 1'b0;
        end
        if (o_done_req != '0) begin
          if (sb.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_done: got %b expected none", o_done_req);
          end else begin
            e = sb.pop_front();
            chk("done_owner", W'(o_done_req), W'(e.who));
            chk("product", o_o_req, e.prod);
          end
        end
      end
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got no finish expected finish before 2 ms");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    i_rst       = 1'b1;
    i_start_req = '0;
    i_x_req     = '0;
    i_y_req     = '0;

    // Reset held 100 ns with a stray multiplier done in the middle.
    repeat (4) @(negedge i_clk);
    stray_o    = 32'hDEADBEEF;
    stray_done = 1'b1;
    @(negedge i_clk);
    stray_done = 1'b0;
    chk("rst_done_stray", W'(o_done_req), 32'h0);
    repeat (5) @(negedge i_clk);
    i_rst = 1'b0;
    @(negedge i_clk);
    chk("rst_done", W'(o_done_req), 32'h0);
    chk("rst_o", o_o_req, 32'h0);
    chk("rst_busy", W'(o_busy_req), 32'h0);
    chk("rst_start", W'(o_start_mul), 32'h0);
    chk("rst_x_mul", o_x_mul, 32'h0);
    chk("rst_y_mul", o_y_mul, 32'h0);

    // Contention: all four at once, grants 0,1,2,3.
    for (int k = 0; k < N; k++) begin
      set_req(k, 32'h00000001, 32'h11111111 * (k + 1));
      push(k, 32'h11111111 * (k + 1));
    end
    s0 = n_starts;
    fire(4'b1111);
    chk("contention_busy", W'(o_busy_req), 32'hF);
    repeat (4) wait_done();
    repeat (4) @(negedge i_clk);
    chk("contention_starts", W'(n_starts - s0), 32'd4);
    chk("contention_idle_busy", W'(o_busy_req), 32'h0);

    // Fairness: req0 re-requests on its done while req2 is pending.
    set_req(0, 32'h00000001, 32'hA0000001);
    set_req(2, 32'h00000001, 32'h0000C0DE);
    push(0, 32'hA0000001);
    push(2, 32'h0000C0DE);
    fire(4'b0101);
    wait_done();
    chk("fair_busy_a", W'(o_busy_req), 32'h4);
    set_req(0, 32'h00000001, 32'hA0000002);
    push(0, 32'hA0000002);
    fire(4'b0001);
    wait_done();
    chk("fair_busy_b", W'(o_busy_req), 32'h1);
    set_req(2, 32'h00000001, 32'h0000C0DF);
    push(2, 32'h0000C0DF);
    fire(4'b0100);
    wait_done();
    chk("fair_busy_c", W'(o_busy_req), 32'h4);
    wait_done();
    chk("fair_busy_d", W'(o_busy_req), 32'h0);

    // Zero product, and a start while busy is dropped.
    set_req(1, 32'h00000000, 32'hFFFFFFFF);
    push(1, 32'h00000000);
    fire(4'b0010);
    repeat (2) @(negedge i_clk);
    set_req(1, 32'h00000001, 32'h00000005);
    fire(4'b0010);
    wait_done();
    repeat (15) @(negedge i_clk);
    chk("ignore_sb_empty", W'(sb.size()), 32'd0);
    chk("ignore_busy", W'(o_busy_req), 32'h0);

    // Single request: start_mul two cycles after the start pulse, result held afterwards.
    set_req(0, 32'h00000001, 32'h12345678);
    push(0, 32'h12345678);
    fire(4'b0001);
    chk("single_start_e1", W'(o_start_mul), 32'h0);
    @(negedge i_clk);
    chk("single_start_e2", W'(o_start_mul), 32'h1);
    @(negedge i_clk);
    chk("single_start_e3", W'(o_start_mul), 32'h0);
    wait_done();
    repeat (3) @(negedge i_clk);
    chk("single_hold_o", o_o_req, 32'h12345678);
    chk("single_done_low", W'(o_done_req), 32'h0);

    // Reset while waiting on the multiplier; its late done must be ignored.
    set_req(3, 32'h00000001, 32'hA5A5A5A5);
    fire(4'b1000);
    begin
      logic seen;
      seen = 1'b0;
      for (int c = 0; c < 10 && !seen; c++) begin
        if (o_start_mul) seen = 1'b1;
        else @(negedge i_clk);
      end
      chk("midrst_start_seen", W'(seen), 32'h1);
    end
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    chk("midrst_busy", W'(o_busy_req), 32'h0);
    chk("midrst_o", o_o_req, 32'h0);
    repeat (12) @(negedge i_clk);
    chk("midrst_done_low", W'(o_done_req), 32'h0);
    set_req(3, 32'h00000001, 32'h5A5A5A5A);
    push(3, 32'h5A5A5A5A);
    fire(4'b1000);
    wait_done();

    // Real field arithmetic: x * x^31 wraps to the reduction polynomial, (x+1)(x^2+1).
    set_req(2, 32'h00000002, 32'h80000000);
    push(2, 32'h0000008D);
    fire(4'b0100);
    wait_done();
    set_req(1, 32'h00000003, 32'h00000005);
    push(1, 32'h0000000F);
    fire(4'b0010);
    wait_done();
    repeat (10) @(negedge i_clk);
    chk("final_sb_empty", W'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
